// File: rtl/rt_write_dispatch_pkg.sv
// Shared constants for the real-time block-write dispatcher: register offsets,
// per-channel quadlet bit positions and FSM state encodings.
package rt_write_dispatch_pkg;

    localparam logic [3:0] OFF_DAC    = 4'h1;
    localparam logic [3:0] OFF_AMP_EN = 4'h0;

    localparam int Q_VALID_BIT    = 31;
    localparam int Q_EN_VALID_BIT = 29;
    localparam int Q_AMP_EN_BIT   = 28;
    localparam int Q_DAC_MSB      = 15;
    localparam int Q_SEQ_MSB      = 15;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_COLLECT    = 3'd1;
    localparam state_t ST_WAIT_GRANT = 3'd2;
    localparam state_t ST_DISPATCH   = 3'd3;
    localparam state_t ST_DONE       = 3'd4;

endpackage

// File: rtl/rt_write_dispatch.sv
// Collects one real-time block write (sequence quadlet plus one quadlet per motor
// channel) and, when complete, replays it as DAC / amp-enable register writes.
module rt_write_dispatch
    import rt_write_dispatch_pkg::*;
#(
    parameter int NUM_CHAN = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             blk_wstart,
    input  logic             blk_wen,
    input  logic [5:0]       blk_waddr,
    input  logic [31:0]      blk_wdata,
    input  logic             blk_wdone,
    output logic             bus_req,
    input  logic             bus_grant,
    output logic             reg_wen,
    output logic [7:0]       reg_waddr,
    output logic [31:0]      reg_wdata,
    output logic [15:0]      rt_seq,
    output logic [ERR_W-1:0] err_count,
    output logic             isBusy,
    output logic             done,
    output logic [2:0]       dbg_state
);

    localparam int SLOT_W = (2 * NUM_CHAN > 2) ? $clog2(2 * NUM_CHAN) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(2 * NUM_CHAN - 1);

    state_t            state_q, state_d;
    logic [NUM_CHAN:0] mask_q, mask_d;
    logic              bad_q, bad_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [31:0]       qbuf_q [0:NUM_CHAN];
    logic [31:0]       qbuf_d [0:NUM_CHAN];

    logic              bus_req_q, bus_req_d;
    logic              reg_wen_q, reg_wen_d;
    logic [7:0]        reg_waddr_q, reg_waddr_d;
    logic [31:0]       reg_wdata_q, reg_wdata_d;
    logic [15:0]       rt_seq_q, rt_seq_d;
    logic [ERR_W-1:0]  err_count_q, err_count_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              err_inc;
    logic [3:0]        chan;
    logic [31:0]       chan_q;
    logic              unused_chan_bits;

    // bus_req/bus_grant act as valid/ready: a slot is consumed (and its write,
    // if any, issued) only on a cycle where bus_grant is sampled high while
    // bus_req is asserted; otherwise the slot holds and reg_wen stays low.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        bad_d       = bad_q;
        slot_d      = slot_q;
        qbuf_d      = qbuf_q;
        reg_wen_d   = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        rt_seq_d    = rt_seq_q;
        done_d      = 1'b0;
        err_inc     = 1'b0;
        chan        = 4'(slot_q >> 1) + 4'd1;
        chan_q      = '0;
        for (int i = 1; i <= NUM_CHAN; i++) begin
            if (chan == 4'(i)) chan_q = qbuf_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (blk_wstart) begin
                    state_d = ST_COLLECT;
                    mask_d  = '0;
                    bad_d   = 1'b0;
                end
            end
            ST_COLLECT: begin
                if (blk_wstart) begin
                    mask_d = '0;
                    bad_d  = 1'b0;
                end else begin
                    if (blk_wen) begin
                        if (blk_waddr > 6'(NUM_CHAN)) begin
                            bad_d = 1'b1;
                        end else begin
                            for (int i = 0; i <= NUM_CHAN; i++) begin
                                if (blk_waddr == 6'(i)) begin
                                    qbuf_d[i] = blk_wdata;
                                    mask_d[i] = 1'b1;
                                end
                            end
                        end
                    end
                    // Same-cycle quadlet is already folded into mask_d/qbuf_d here.
                    if (blk_wdone) begin
                        if (&mask_d && !bad_d) begin
                            rt_seq_d = qbuf_d[0][Q_SEQ_MSB:0];
                            state_d  = ST_WAIT_GRANT;
                        end else begin
                            err_inc = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_WAIT_GRANT: begin
                err_inc = blk_wstart;
                if (bus_grant) begin
                    state_d = ST_DISPATCH;
                    slot_d  = '0;
                end
            end
            ST_DISPATCH: begin
                err_inc = blk_wstart;
                if (bus_grant) begin
                    if (!slot_q[0]) begin
                        reg_wen_d = chan_q[Q_VALID_BIT];
                        if (chan_q[Q_VALID_BIT]) begin
                            reg_waddr_d = {chan, OFF_DAC};
                            reg_wdata_d = {16'd0, chan_q[Q_DAC_MSB:0]};
                        end
                    end else begin
                        reg_wen_d = chan_q[Q_EN_VALID_BIT];
                        if (chan_q[Q_EN_VALID_BIT]) begin
                            reg_waddr_d = {chan, OFF_AMP_EN};
                            reg_wdata_d = {31'd0, chan_q[Q_AMP_EN_BIT]};
                        end
                    end
                    if (slot_q == LAST_SLOT) state_d = ST_DONE;
                    else                     slot_d  = slot_q + SLOT_W'(1);
                end
            end
            ST_DONE: begin
                err_inc = blk_wstart;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        bus_req_d   = (state_d == ST_WAIT_GRANT) || (state_d == ST_DISPATCH);
        busy_d      = (state_d != ST_IDLE);
        err_count_d = (err_inc && (err_count_q != '1)) ? err_count_q + ERR_W'(1) : err_count_q;
    end

    assign unused_chan_bits = ^{chan_q[30], chan_q[27:16]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            bad_q       <= 1'b0;
            slot_q      <= '0;
            bus_req_q   <= 1'b0;
            reg_wen_q   <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            rt_seq_q    <= '0;
            err_count_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            bad_q       <= bad_d;
            slot_q      <= slot_d;
            bus_req_q   <= bus_req_d;
            reg_wen_q   <= reg_wen_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            rt_seq_q    <= rt_seq_d;
            err_count_q <= err_count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Quadlet storage is qualified by the mask, so it carries no reset.
    always_ff @(posedge clk) begin
        qbuf_q <= qbuf_d;
    end

    assign bus_req   = bus_req_q;
    assign reg_wen   = reg_wen_q;
    assign reg_waddr = reg_waddr_q;
    assign reg_wdata = reg_wdata_q;
    assign rt_seq    = rt_seq_q;
    assign err_count = err_count_q;
    assign isBusy    = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rt_write_dispatch.sv
// Directed and randomized packets against a packet-level reference model of the
// real-time write dispatcher.
`timescale 1ns/1ps
module tb_rt_write_dispatch;

    localparam int NC  = 4;
    localparam int EW  = 8;
    localparam int SAT = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          blk_wstart, blk_wen, blk_wdone;
    logic [5:0]    blk_waddr;
    logic [31:0]   blk_wdata;
    logic          bus_req, bus_grant, reg_wen, isBusy, done;
    logic [7:0]    reg_waddr;
    logic [31:0]   reg_wdata;
    logic [15:0]   rt_seq;
    logic [EW-1:0] err_count;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    rt_write_dispatch #(.NUM_CHAN(NC), .ERR_W(EW)) dut (
        .clk(clk), .reset(reset),
        .blk_wstart(blk_wstart), .blk_wen(blk_wen), .blk_waddr(blk_waddr),
        .blk_wdata(blk_wdata), .blk_wdone(blk_wdone),
        .bus_req(bus_req), .bus_grant(bus_grant),
        .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .rt_seq(rt_seq), .err_count(err_count), .isBusy(isBusy), .done(done),
        .dbg_state(dbg_state)
    );

    // 0: grant held high, 1: random grant, 2: grant held low
    int   grant_mode = 0;
    logic rand_bit = 1'b1;
    assign bus_grant = (grant_mode == 0) ? 1'b1 : (grant_mode == 2) ? 1'b0 : rand_bit;
    always begin
        @(posedge clk);
        #2;
        rand_bit = ($urandom_range(0, 3) != 0);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every write, done pulse and bus_req cycle, sampled mid-cycle.
    logic [39:0] obs_q[$];
    int done_cnt = 0, done_cyc = 0, breq_cnt = 0;
    always @(negedge clk) begin
        if (reg_wen) obs_q.push_back({reg_waddr, reg_wdata});
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (bus_req) breq_cnt = breq_cnt + 1;
    end

    int n_vec = 0, n_err = 0;
    logic [5:0]  w_addr[$];
    logic [31:0] w_data[$];
    bit          done_with_last;
    logic [39:0] exp_q[$];
    bit          exp_ok;
    logic [15:0] mdl_seq = '0;
    int          mdl_err = 0;
    int          obs_base, done_base, breq_base;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic err_bump();
        if (mdl_err != SAT) mdl_err++;
    endtask

    // Packet-level model: accept iff every quadlet 0..NC arrived and no address
    // was out of range; the last write to each index wins.
    task automatic model_packet();
        logic [31:0] q [0:NC];
        bit          got [0:NC];
        bit          bad;
        int          a;
        bad = 1'b0;
        for (int k = 0; k <= NC; k++) begin
            q[k]   = '0;
            got[k] = 1'b0;
        end
        for (int i = 0; i < w_addr.size(); i++) begin
            a = int'(w_addr[i]);
            if (a > NC) bad = 1'b1;
            else begin
                q[a]   = w_data[i];
                got[a] = 1'b1;
            end
        end
        exp_ok = !bad;
        for (int k = 0; k <= NC; k++) if (!got[k]) exp_ok = 1'b0;
        exp_q.delete();
        if (exp_ok) begin
            mdl_seq = q[0][15:0];
            for (int k = 1; k <= NC; k++) begin
                if (q[k][31]) exp_q.push_back({4'(k), 4'h1, 16'h0, q[k][15:0]});
                if (q[k][29]) exp_q.push_back({4'(k), 4'h0, 31'h0, q[k][28]});
            end
        end else begin
            err_bump();
        end
    endtask

    task automatic load5(input logic [31:0] d0, d1, d2, d3, d4);
        w_addr.delete();
        w_data.delete();
        w_addr.push_back(6'd0); w_data.push_back(d0);
        w_addr.push_back(6'd1); w_data.push_back(d1);
        w_addr.push_back(6'd2); w_data.push_back(d2);
        w_addr.push_back(6'd3); w_data.push_back(d3);
        w_addr.push_back(6'd4); w_data.push_back(d4);
        done_with_last = 1'b0;
    endtask

    task automatic build_random();
        int order[$];
        int j, tmp, drop;
        w_addr.delete();
        w_data.delete();
        for (int k = 0; k <= NC; k++) order.push_back(k);
        for (int k = NC; k > 0; k--) begin
            j = $urandom_range(0, k);
            tmp = order[k]; order[k] = order[j]; order[j] = tmp;
        end
        drop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NC) : -1;
        for (int k = 0; k <= NC; k++) begin
            if (order[k] != drop) begin
                w_addr.push_back(6'(order[k]));
                w_data.push_back($urandom);
            end
        end
        if ($urandom_range(0, 4) == 0) begin
            j = $urandom_range(0, w_addr.size());
            w_addr.insert(j, 6'($urandom_range(NC + 1, 63)));
            w_data.insert(j, $urandom);
        end
        if ($urandom_range(0, 3) == 0) begin
            w_addr.push_back(6'($urandom_range(0, NC)));
            w_data.push_back($urandom);
        end
        done_with_last = ($urandom_range(0, 1) == 1);
    endtask

    task automatic drive_packet(output int wdone_at);
        blk_wstart = 1'b1;
        tick();
        blk_wstart = 1'b0;
        for (int i = 0; i < w_addr.size(); i++) begin
            blk_wen   = 1'b1;
            blk_waddr = w_addr[i];
            blk_wdata = w_data[i];
            if (done_with_last && (i == w_addr.size() - 1)) blk_wdone = 1'b1;
            tick();
        end
        blk_wen = 1'b0;
        if (!blk_wdone) begin
            blk_wdone = 1'b1;
            tick();
        end
        blk_wdone = 1'b0;
        wdone_at  = cyc;
    endtask

    task automatic send_packet(input string tag, input int gap_after, input bit extra_wstart,
                               input bit check_lat);
        int wdone_at, seen, lat_extra, n_obs;
        model_packet();
        obs_base  = obs_q.size();
        done_base = done_cnt;
        breq_base = breq_cnt;
        lat_extra = 0;
        drive_packet(wdone_at);
        if (extra_wstart) begin
            blk_wstart = 1'b1;
            tick();
            blk_wstart = 1'b0;
            err_bump();
        end
        if (gap_after > 0) begin
            seen = 0;
            for (int t = 0; t < 100 && seen < gap_after; t++) begin
                tick();
                if (reg_wen) seen++;
            end
            grant_mode = 2;
            for (int t = 0; t < 3; t++) begin
                tick();
                chk({tag, " gap wen"}, 64'(reg_wen), 64'd0);
            end
            grant_mode = 0;
            lat_extra  = 3;
        end
        if (exp_ok) begin
            for (int t = 0; t < 200 && done_cnt == done_base; t++) tick();
            // One edge to sample grant, one per slot, one to register done.
            if (check_lat) chk({tag, " done latency"}, 64'(done_cyc - wdone_at), 64'(2 * NC + 2 + lat_extra));
        end else begin
            repeat (4) tick();
            chk({tag, " bus_req cycles"}, 64'(breq_cnt - breq_base), 64'd0);
        end
        tick();
        chk({tag, " done pulses"}, 64'(done_cnt - done_base), exp_ok ? 64'd1 : 64'd0);
        n_obs = obs_q.size() - obs_base;
        chk({tag, " write count"}, 64'(n_obs), 64'(exp_q.size()));
        for (int i = 0; i < n_obs && i < exp_q.size(); i++)
            chk({tag, " write"}, 64'(obs_q[obs_base + i]), 64'(exp_q[i]));
        chk({tag, " rt_seq"}, 64'(rt_seq), 64'(mdl_seq));
        chk({tag, " err_count"}, 64'(err_count), 64'(mdl_err));
        chk({tag, " idle"}, 64'(isBusy), 64'd0);
    endtask

    initial begin
        int wd;
        reset      = 1'b1;
        blk_wstart = 1'b0;
        blk_wen    = 1'b0;
        blk_wdone  = 1'b0;
        blk_waddr  = '0;
        blk_wdata  = '0;
        repeat (2) tick();
        chk("rst bus_req", 64'(bus_req), 64'd0);
        chk("rst reg_wen", 64'(reg_wen), 64'd0);
        chk("rst reg_waddr", 64'(reg_waddr), 64'd0);
        chk("rst reg_wdata", 64'(reg_wdata), 64'd0);
        chk("rst rt_seq", 64'(rt_seq), 64'd0);
        chk("rst err_count", 64'(err_count), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst isBusy", 64'(isBusy), 64'd0);
        reset = 1'b0;
        tick();

        load5(32'h0000_1234, 32'h8000_0100, 32'h8000_0200, 32'h8000_0300, 32'h8000_0400);
        send_packet("s1", 0, 1'b0, 1'b1);
        chk("s1 first write", 64'(obs_q[obs_base]), 64'h11_0000_0100);
        chk("s1 seq literal", 64'(rt_seq), 64'h1234);

        load5(32'h0000_0042, 32'h0, 32'h3000_0000, 32'h0, 32'h0);
        send_packet("s2", 0, 1'b0, 1'b1);
        chk("s2 only write", 64'(obs_q[obs_base]), 64'h20_0000_0001);

        load5(32'h0000_0077, 32'h8000_0001, 32'h8000_0002, 32'h8000_0003, 32'h8000_0004);
        w_addr.delete(3);
        w_data.delete(3);
        send_packet("s3", 0, 1'b0, 1'b0);

        load5(32'h0000_0099, 32'hA000_0011, 32'hA000_0022, 32'hB000_0033, 32'h8000_0044);
        w_addr.insert(2, 6'd6);
        w_data.insert(2, 32'hDEAD_BEEF);
        send_packet("s4", 0, 1'b0, 1'b0);

        load5(32'h0000_0555, 32'h8000_0A01, 32'h8000_0A02, 32'h8000_0A03, 32'h8000_0A04);
        send_packet("s5", 2, 1'b0, 1'b1);

        load5(32'h0000_0666, 32'hB000_0B01, 32'h8000_0B02, 32'h2000_0B03, 32'h8000_0B04);
        send_packet("wstart busy", 0, 1'b1, 1'b1);

        load5(32'h0000_0777, 32'h8000_0C01, 32'h8000_0C02, 32'h8000_0C03, 32'h8000_0C04);
        model_packet();
        obs_base = obs_q.size();
        drive_packet(wd);
        repeat (4) tick();
        chk("s6 busy before rst", 64'(isBusy), 64'd1);
        chk("s6 bus_req before rst", 64'(bus_req), 64'd1);
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        mdl_seq = '0;
        mdl_err = 0;
        chk("s6 bus_req after rst", 64'(bus_req), 64'd0);
        chk("s6 reg_wen after rst", 64'(reg_wen), 64'd0);
        chk("s6 rt_seq after rst", 64'(rt_seq), 64'd0);
        repeat (12) tick();
        chk("s6 writes before rst", 64'(obs_q.size() - obs_base), 64'd2);
        load5(32'h0000_0888, 32'h8000_0D01, 32'h3000_0000, 32'h8000_0D03, 32'hA000_0D04);
        send_packet("s6 after rst", 0, 1'b0, 1'b1);
        for (int p = 0; p < 300; p++) begin
            w_addr.delete();
            w_data.delete();
            done_with_last = 1'b0;
            model_packet();
            drive_packet(wd);
            tick();
        end
        chk("s6 err saturate", 64'(err_count), 64'(SAT));
        chk("s6 model saturate", 64'(mdl_err), 64'(SAT));

        grant_mode = 1;
        for (int p = 0; p < 40; p++) begin
            build_random();
            send_packet("rand", 0, 1'b0, 1'b0);
        end
        grant_mode = 0;
        for (int p = 0; p < 10; p++) begin
            build_random();
            send_packet("rand steady", 0, 1'b0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
